latch_write_sched: RTL and testbench

//  Scheduler that shares one data bus into a bank of level-sensitive D latches (EN/D/Q cells) among NREQ requesters.

---
 rtl/latch_sched_pkg.sv | 22 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/latch_write_sched.sv | 110 +++++++++++
 tb/tb_latch_write_sched.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/latch_sched_pkg.sv
// Shared types and sizing helpers for the latch write scheduler.
// Combinational only: no latency, no backpressure.
package latch_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_STROBE = 2'd2,
    ST_HOLD   = 2'd3
  } state_t;

  // Width of an index or counter; never collapses to zero bits.
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // The phase counter covers whichever of the setup and strobe phases is longer.
  function automatic int cnt_w(input int setup_cyc, input int en_cyc);
    return clog2_min1((setup_cyc > en_cyc) ? setup_cyc : en_cyc);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first set req at or after ptr, wrapping; one-hot grant plus index.
// Purely combinational, zero latency; requesters hold req until served.
module rr_arbiter
  import latch_sched_pkg::*;
#(
  parameter int NREQ = 4,
  localparam int PW = clog2_min1(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [PW-1:0]   idx,
  output logic            any
);

  always_comb begin
    int j;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    j   = 0;
    for (int i = 0; i < NREQ; i++) begin
      j = (int'(ptr) + i) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = PW'(j);
      end
    end
  end

endmodule

// File: rtl/latch_write_sched.sv
// Shares one D bus into a latch bank: grant, SETUP_CYC setup, EN_CYC strobe, 1 hold (DONE).
// Requesters hold REQ until DONE; define LATCH_READBACK_EN for Q readback and ERR.
module latch_write_sched
  import latch_sched_pkg::*;
#(
  parameter int NREQ      = 4,
  parameter int NLAT      = 4,
  parameter int DW        = 1,
  parameter int SETUP_CYC = 1,
  parameter int EN_CYC    = 2,
  localparam int SEL_W    = clog2_min1(NLAT)
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [NREQ-1:0]       REQ,
  input  logic [NREQ*DW-1:0]    WDATA,
  input  logic [NREQ*SEL_W-1:0] WSEL,
  output logic [NREQ-1:0]       GNT,
  output logic [NREQ-1:0]       DONE,
  output logic [DW-1:0]         D,
  output logic [NLAT-1:0]       EN,
  output logic                  BUSY
`ifdef LATCH_READBACK_EN
  ,
  input  logic [NLAT*DW-1:0]    Q,
  output logic                  ERR
`endif
);

  localparam int PW = clog2_min1(NREQ);
  localparam int CW = cnt_w(SETUP_CYC, EN_CYC);

  state_t           state, nxt;
  logic [CW-1:0]    cnt;
  logic [NREQ-1:0]  gnt_q;
  logic [PW-1:0]    win_q, ptr_q;
  logic [SEL_W-1:0] sel_q;
  logic [DW-1:0]    d_q;

  logic [NREQ-1:0]  arb_gnt;
  logic [PW-1:0]    arb_idx;
  logic             arb_any;

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req (REQ),
    .ptr (ptr_q),
    .gnt (arb_gnt),
    .idx (arb_idx),
    .any (arb_any)
  );

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:   if (arb_any) nxt = ST_SETUP;
      ST_SETUP:  if (cnt == CW'(SETUP_CYC - 1)) nxt = ST_STROBE;
      ST_STROBE: if (cnt == CW'(EN_CYC - 1)) nxt = ST_HOLD;
      ST_HOLD:   nxt = ST_IDLE;
      default:   nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= ST_IDLE;
      cnt   <= '0;
      gnt_q <= '0;
      win_q <= '0;
      ptr_q <= '0;
      sel_q <= '0;
      d_q   <= '0;
    end else begin
      state <= nxt;
      cnt   <= (nxt != state) ? '0 : cnt + 1'b1;
      // Data and select are frozen here; later WDATA/WSEL changes are ignored.
      if (state == ST_IDLE && arb_any) begin
        gnt_q <= arb_gnt;
        win_q <= arb_idx;
        d_q   <= WDATA[int'(arb_idx)*DW +: DW];
        sel_q <= WSEL[int'(arb_idx)*SEL_W +: SEL_W];
      end
      if (state == ST_HOLD) begin
        gnt_q <= '0;
        ptr_q <= (win_q == PW'(NREQ - 1)) ? '0 : win_q + 1'b1;
      end
    end
  end

  assign GNT  = gnt_q;
  assign DONE = (state == ST_HOLD) ? gnt_q : '0;
  assign D    = d_q;
  assign BUSY = (state != ST_IDLE);

  // Decoding by comparison leaves an out-of-range select with no EN bit at all.
  always_comb begin
    EN = '0;
    for (int i = 0; i < NLAT; i++)
      EN[i] = (state == ST_STROBE) && (sel_q == SEL_W'(i));
  end

`ifdef LATCH_READBACK_EN
  always_comb begin
    ERR = 1'b0;
    if (state == ST_HOLD)
      for (int i = 0; i < NLAT; i++)
        if (sel_q == SEL_W'(i) && Q[i*DW +: DW] != d_q) ERR = 1'b1;
  end
`endif

endmodule

// File: tb/tb_latch_write_sched.sv
// Directed bench: behavioural latch bank on D/EN, hand-computed expectations.
// A second instance with NLAT=5 exercises an out-of-range select.
module tb_latch_write_sched;

  logic        CLK = 1'b0;
  logic        RST;
  logic [3:0]  REQ, WDATA, GNT, DONE, EN;
  logic [7:0]  WSEL;
  logic        D, BUSY;

  logic [3:0]  REQ2, WDATA2, GNT2, DONE2;
  logic [11:0] WSEL2;
  logic [4:0]  EN2;
  logic        D2, BUSY2;

  logic        lat_clr;
  logic [3:0]  lat_q;
  logic        stuck3;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 CLK = ~CLK;

  always_latch begin
    for (int i = 0; i < 4; i++)
      if (lat_clr) lat_q[i] <= 1'b0;
      else if (EN[i]) lat_q[i] <= D;
  end

`ifdef LATCH_READBACK_EN
  logic [3:0] Q;
  logic       ERR;
  logic [4:0] Q2;
  logic       ERR2;
  assign Q  = stuck3 ? (lat_q & 4'b0111) : lat_q;
  assign Q2 = 5'b0;
`endif

  latch_write_sched #(.NREQ(4), .NLAT(4), .DW(1), .SETUP_CYC(1), .EN_CYC(2)) u_dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WDATA(WDATA), .WSEL(WSEL),
    .GNT(GNT), .DONE(DONE), .D(D), .EN(EN), .BUSY(BUSY)
`ifdef LATCH_READBACK_EN
    , .Q(Q), .ERR(ERR)
`endif
  );

  latch_write_sched #(.NREQ(4), .NLAT(5), .DW(1), .SETUP_CYC(1), .EN_CYC(2)) u_dut5 (
    .CLK(CLK), .RST(RST), .REQ(REQ2), .WDATA(WDATA2), .WSEL(WSEL2),
    .GNT(GNT2), .DONE(DONE2), .D(D2), .EN(EN2), .BUSY(BUSY2)
`ifdef LATCH_READBACK_EN
    , .Q(Q2), .ERR(ERR2)
`endif
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset();
    RST = 1'b1;
    lat_clr = 1'b1;
    tick();
    RST = 1'b0;
    lat_clr = 1'b0;
  endtask

  initial begin
    RST = 1'b1; lat_clr = 1'b1; stuck3 = 1'b0;
    REQ = '0; WDATA = '0; WSEL = '0;
    REQ2 = '0; WDATA2 = '0; WSEL2 = '0;
    tick(); tick();
    check("rst_gnt", GNT, 0);
    check("rst_done", DONE, 0);
    check("rst_d", D, 0);
    check("rst_en", EN, 0);
    check("rst_busy", BUSY, 0);
    RST = 1'b0; lat_clr = 1'b0;

    // 1: single write of 1 to latch 2
    REQ = 4'b0001; WDATA = 4'b0001; WSEL = 8'h02;
    check("t1_idle_gnt", GNT, 0);
    tick();
    check("t1_gnt", GNT, 4'b0001);
    check("t1_setup_en", EN, 0);
    check("t1_setup_d", D, 1);
    check("t1_busy", BUSY, 1);
    tick();
    check("t1_strobe1_en", EN, 4'b0100);
    tick();
    check("t1_strobe2_en", EN, 4'b0100);
    check("t1_strobe2_done", DONE, 0);
    tick();
    check("t1_hold_en", EN, 0);
    check("t1_hold_done", DONE, 4'b0001);
    check("t1_latches", lat_q, 4'b0100);
    REQ = '0;
    tick();
    check("t1_idle_done", DONE, 0);
    check("t1_idle_gnt2", GNT, 0);
    check("t1_idle_d", D, 1);
    check("t1_idle_busy", BUSY, 0);

    // 2: all four requesting, grants 0,1,2,3,0 with requester i writing latch i
    do_reset();
    REQ = 4'hF; WDATA = 4'b0101; WSEL = 8'he4;
    for (int k = 0; k < 5; k++) begin
      logic [3:0] oh;
      logic       ed;
      oh = 4'b0001 << (k % 4);
      ed = ((k % 4) % 2 == 0) ? 1'b1 : 1'b0;
      tick();
      check("t2_gnt", GNT, oh);
      check("t2_setup_en", EN, 0);
      tick();
      check("t2_strobe1_en", EN, oh);
      tick();
      check("t2_strobe2_en", EN, oh);
      tick();
      check("t2_hold_done", DONE, oh);
      check("t2_hold_d", D, ed);
      if (k == 4) REQ = '0;
      tick();
      check("t2_idle_busy", BUSY, 0);
    end
    check("t2_latches", lat_q, 4'b0101);

    // 3: WDATA/WSEL change after grant must not reach the bus
    do_reset();
    REQ = 4'b0001; WDATA = 4'b0001; WSEL = 8'h03;
    tick();
    check("t3_setup_d", D, 1);
    for (int c = 0; c < 3; c++) begin
      WDATA = (c % 2 == 0) ? 4'b0000 : 4'b0001;
      WSEL = 8'h00;
      tick();
      check("t3_d_stable", D, 1);
      if (c < 2) check("t3_en", EN, 4'b1000);
    end
    check("t3_hold_done", DONE, 4'b0001);
    check("t3_latches", lat_q, 4'b1000);
    REQ = '0;
    tick();

    // 4: reset during strobe abandons the transaction
    do_reset();
    REQ = 4'b0010; WDATA = 4'b0010; WSEL = 8'h04;
    tick();
    check("t4_gnt", GNT, 4'b0010);
    tick();
    check("t4_strobe_en", EN, 4'b0010);
    RST = 1'b1;
    tick();
    check("t4_en", EN, 0);
    check("t4_gnt0", GNT, 0);
    check("t4_busy", BUSY, 0);
    check("t4_done", DONE, 0);
    check("t4_d", D, 0);
    RST = 1'b0; REQ = '0;
    tick();
    check("t4_done_after", DONE, 0);

    // 5: NLAT=5 instance, select 5 is out of range, then select 4 in range
    do_reset();
    REQ2 = 4'b0010; WDATA2 = 4'b0010; WSEL2 = 12'h028;
    for (int c = 0; c < 4; c++) begin
      tick();
      check("t5_en_off", EN2, 0);
    end
    check("t5_done", DONE2, 4'b0010);
    WSEL2 = 12'h020;
    tick();
    check("t5_idle_busy", BUSY2, 0);
    tick();
    check("t5_regrant", GNT2, 4'b0010);
    tick();
    check("t5_en_on", EN2, 5'b10000);
    tick();
    tick();
    check("t5_done2", DONE2, 4'b0010);
    REQ2 = '0;
    tick();
    check("t5_main_en", EN, 0);

`ifdef LATCH_READBACK_EN
    // 6: readback with latch 3 stuck at 0, then healthy
    do_reset();
    stuck3 = 1'b1;
    REQ = 4'b0001; WDATA = 4'b0001; WSEL = 8'h03;
    tick();
    check("t6_setup_err", ERR, 0);
    tick(); tick(); tick();
    check("t6_done", DONE, 4'b0001);
    check("t6_err", ERR, 1);
    REQ = '0;
    tick();
    check("t6_idle_err", ERR, 0);
    stuck3 = 1'b0;
    REQ = 4'b0001;
    tick(); tick(); tick(); tick();
    check("t6_done_ok", DONE, 4'b0001);
    check("t6_err_ok", ERR, 0);
    REQ = '0;
    tick();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
